// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared types and constants for the I2S/TDM receive deserialiser.
//   i2s_state_e : receiver FSM states (IDLE, SYNC, RUN)
//   bit_idx_t   : index of a bit within a word (0..I2S_MAX_BITS-1)
//   word_idx_t  : index of a word within a WS half-frame (0..I2S_MAX_WORDS-1)
//   size_mask() : mask keeping bits [size:0] of a word
package i2s_pkg;

  localparam int I2S_MAX_BITS  = 32;
  localparam int I2S_MAX_WORDS = 16;

  typedef logic [$clog2(I2S_MAX_BITS)-1:0]  bit_idx_t;
  typedef logic [$clog2(I2S_MAX_WORDS)-1:0] word_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } i2s_state_e;

  // size is "bits per word minus 1"; bits above it are forced to zero.
  function automatic logic [I2S_MAX_BITS-1:0] size_mask(input bit_idx_t size);
    return {I2S_MAX_BITS{1'b1}} >> (bit_idx_t'(I2S_MAX_BITS - 1) - size);
  endfunction

endpackage

// File: rtl/i2s_rx_deser_if.sv
// i2s_rx_deser_if -- received-word handshake between the deserialiser and its consumer.
//   data_o       : received word, right-justified
//   data_ch_o    : {WS half (0 = WS low), word index within the half}
//   data_valid_o : word available, held until accepted
//   data_ready_i : consumer accepts the word on a posedge where valid is high
// master = deserialiser side, slave = consumer side.
interface i2s_rx_deser_if;
  import i2s_pkg::*;

  logic [I2S_MAX_BITS-1:0] data_o;
  logic [4:0]              data_ch_o;
  logic                    data_valid_o;
  logic                    data_ready_i;

  modport master (
    output data_o,
    output data_ch_o,
    output data_valid_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o,
    input  data_ch_o,
    input  data_valid_o,
    output data_ready_i
  );

endinterface

// File: rtl/i2s_rx_shifter.sv
// i2s_rx_shifter -- assembles serial bits into a word.
//   sck_i, rstn_i   : bit clock, async active-low reset
//   shift_en_i      : sample sd_i into the word this posedge
//   clr_i           : empty the assembly register this posedge (wins over shift)
//   lsb_first_i     : 1 = bit_idx_i selects the destination bit, 0 = shift in from the LSB
//   bit_idx_i       : position of the current bit within the word
//   data_size_i     : bits per word minus 1
//   sd_i            : serial data
//   word_o          : word including the bit on sd_i this cycle, bits above data_size_i zeroed
module i2s_rx_shifter
  import i2s_pkg::*;
(
  input  logic                    sck_i,
  input  logic                    rstn_i,
  input  logic                    shift_en_i,
  input  logic                    clr_i,
  input  logic                    lsb_first_i,
  input  bit_idx_t                bit_idx_i,
  input  bit_idx_t                data_size_i,
  input  logic                    sd_i,
  output logic [I2S_MAX_BITS-1:0] word_o
);

  logic [I2S_MAX_BITS-1:0] shreg_q;
  logic [I2S_MAX_BITS-1:0] shreg_nxt;

  // word_o is combinational so the top can capture the word on the same
  // posedge that samples its final bit.
  always_comb begin
    // NOTE: assign the default before any branch so no path leaves
    // shreg_nxt unassigned; otherwise synthesis infers a latch.
    shreg_nxt = shreg_q;
    if (lsb_first_i) begin
      shreg_nxt[bit_idx_i] = sd_i;
    end else begin
      shreg_nxt = {shreg_q[I2S_MAX_BITS-2:0], sd_i};
    end
    word_o = shreg_nxt & size_mask(data_size_i);
  end

  // NOTE: shreg is an ordinary register rather than a memory array, so it
  // takes the asynchronous reset like every other flop.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg_q <= '0;
    end else if (clr_i) begin
      shreg_q <= '0;
    end else if (shift_en_i) begin
      shreg_q <= shreg_nxt;
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser -- I2S / TDM serial receiver with ready/valid word output.
//   sck_i, rstn_i     : bit clock (all state on posedge), async active-low reset
//   cfg_en_i          : receiver enable; low forces IDLE and drops any partial word
//   cfg_lsb_first_i   : 1 = first received bit is the LSB
//   cfg_data_size_i   : bits per word minus 1
//   cfg_word_num_i    : words per WS half-frame minus 1
//   cfg_clr_i         : clears the sticky flags (a same-cycle set wins)
//   ws_i, sd_i        : word select (changes on negedge) and serial data
//   out_if            : data / channel / valid / ready handshake
//   overflow_o        : sticky, a completed word was dropped while the output was full
//   frame_err_o       : sticky, WS changed at a position other than the end of a half-frame
module i2s_rx_deser
  import i2s_pkg::*;
(
  input  logic                  sck_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_lsb_first_i,
  input  logic [4:0]            cfg_data_size_i,
  input  logic [3:0]            cfg_word_num_i,
  input  logic                  cfg_clr_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  i2s_rx_deser_if.master        out_if,
  output logic                  overflow_o,
  output logic                  frame_err_o
);

  i2s_state_e              state_q;
  logic                    r_ws_q;
  bit_idx_t                bit_cnt_q;
  word_idx_t               word_cnt_q;
  logic [I2S_MAX_BITS-1:0] data_q;
  logic [4:0]              ch_q;
  logic                    valid_q;
  logic                    ovf_q;
  logic                    ferr_q;
  logic [I2S_MAX_BITS-1:0] word;

  logic ws_edge, in_run, last_bit, last_word;
  logic frame_bad, word_done, load_word, drop_word;

  assign ws_edge   = ws_i ^ r_ws_q;
  assign in_run    = (state_q == RUN) && cfg_en_i;
  assign last_bit  = (bit_cnt_q == cfg_data_size_i);
  assign last_word = (word_cnt_q == cfg_word_num_i);

  // WS leads data by one bit, so the only legal WS edge is the posedge that
  // samples the final bit of the final word of the half-frame.
  assign frame_bad = in_run && ws_edge && !(last_bit && last_word);
  assign word_done = in_run && last_bit && !frame_bad;
  assign load_word = word_done && (!valid_q || out_if.data_ready_i);
  assign drop_word = word_done && valid_q && !out_if.data_ready_i;

  i2s_rx_shifter u_shifter (
    .sck_i       (sck_i),
    .rstn_i      (rstn_i),
    .shift_en_i  (in_run),
    .clr_i       (!in_run || word_done || frame_bad),
    .lsb_first_i (cfg_lsb_first_i),
    .bit_idx_i   (bit_cnt_q),
    .data_size_i (cfg_data_size_i),
    .sd_i        (sd_i),
    .word_o      (word)
  );

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      r_ws_q     <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      r_ws_q <= ws_i;

      if (drop_word)      ovf_q <= 1'b1;
      else if (cfg_clr_i) ovf_q <= 1'b0;

      if (frame_bad)      ferr_q <= 1'b1;
      else if (cfg_clr_i) ferr_q <= 1'b0;

      if (!cfg_en_i) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        valid_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= SYNC;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end
          SYNC: begin
            // The bit sampled with the WS edge belongs to the previous frame.
            if (ws_edge) state_q <= RUN;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end
          RUN: begin
            // A misplaced WS edge restarts reception exactly as a SYNC lock would.
            if (frame_bad) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
            end else if (last_bit) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= last_word ? '0 : word_cnt_q + word_idx_t'(1);
            end else begin
              bit_cnt_q  <= bit_cnt_q + bit_idx_t'(1);
            end
          end
          default: state_q <= IDLE;
        endcase

        if (load_word) begin
          data_q  <= word;
          ch_q    <= {r_ws_q, word_cnt_q};
          valid_q <= 1'b1;
        end else if (valid_q && out_if.data_ready_i) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_if.data_o       = data_q;
  assign out_if.data_ch_o    = ch_q;
  assign out_if.data_valid_o = valid_q;
  assign overflow_o          = ovf_q;
  assign frame_err_o         = ferr_q;

endmodule

// File: doc/i2s_rx_deser.md
I2S_RX_DESER -- requirements
Module: i2s_rx_deser

Interface
REQ-001 Clocking SHALL be one clock, sck_i; reset SHALL be rstn_i, asynchronous, active-low.
REQ-002 Ports (name direction width meaning), SHALL be exactly:
  sck_i  in  1  bit clock; all state on posedge
  rstn_i  in  1  async active-low reset
  cfg_en_i  in  1  receiver enable
  cfg_lsb_first_i  in  1  1 = first bit received is LSB, 0 = MSB first
  cfg_data_size_i  in  5  bits per word minus 1 (0..31)
  cfg_word_num_i  in  4  words per WS half-frame minus 1 (0..15)
  cfg_clr_i  in  1  clears sticky error flags
  ws_i  in  1  word select, changes on sck_i negedge
  sd_i  in  1  serial data
  data_o  out  32  received word, right-justified, upper bits zero
  data_ch_o  out  5  {ws half (0 = WS low), word index}
  data_valid_o  out  1  word available
  data_ready_i  in  1  consumer accepts word
  overflow_o  out  1  sticky, word dropped
  frame_err_o  out  1  sticky, WS edge at unexpected position

Function
REQ-003 FSM states SHALL be IDLE, SYNC and RUN; cfg_en_i low forces IDLE from any state on the next posedge.
REQ-004 IDLE->SYNC SHALL occur on the posedge where cfg_en_i is high.
REQ-005 A WS edge SHALL be detected on a posedge where ws_i differs from r_ws_q, the ws_i value registered on the previous posedge.
REQ-006 SYNC->RUN SHALL occur on a detected WS edge; the sd_i bit sampled at that posedge SHALL be discarded (I2S one-bit delay).
REQ-007 In RUN, each posedge SHALL shift in sd_i and increment bit_cnt.
  - MSB-first: shreg = {shreg[30:0], sd_i}.
  - LSB-first: shreg[bit_cnt] = sd_i.
REQ-008 When bit_cnt == cfg_data_size_i in RUN, the word SHALL complete on that posedge.
  - bit_cnt SHALL reset to 0.
  - word_cnt SHALL wrap to 0 if it equals cfg_word_num_i, else increment.
  - shreg SHALL clear.
REQ-009 On word completion, data_o SHALL load the assembled word with bits above cfg_data_size_i forced to 0.
  - data_ch_o SHALL load {r_ws_q, word_cnt}.
  - data_valid_o SHALL assert the following cycle (latency one sck after the last bit).
REQ-010 data_valid_o SHALL hold, with data_o and data_ch_o stable, until a posedge with data_ready_i high.
REQ-011 If a word completes while data_valid_o is high and data_ready_i is low, the new word SHALL be dropped and overflow_o SHALL set; the held word SHALL remain unchanged.
REQ-012 If a word completes in the same cycle as data_valid_o && data_ready_i, the new word SHALL load and valid SHALL stay high, with no overflow.
REQ-013 In RUN, a detected WS edge SHALL be expected only when word_cnt == 0 and bit_cnt == 0 after the REQ-008 wrap; the expected edge posedge SHALL carry the final bit of the previous half-frame.
  - Otherwise frame_err_o SHALL set, the partial word SHALL be discarded, the counters SHALL clear, and reception SHALL restart per REQ-006.
REQ-014 cfg_clr_i SHALL clear overflow_o and frame_err_o; a simultaneous set event SHALL win.
REQ-015 Leaving RUN by disable SHALL discard any partial word and clear data_valid_o; cfg_* changes are legal only while cfg_en_i is low.

Reset
REQ-016 On rstn_i low, all of the following SHALL reset immediately to 0:
  - data_o, data_ch_o, data_valid_o, overflow_o, frame_err_o;
  - shreg, bit_cnt, word_cnt, r_ws_q;
  - FSM to IDLE.
REQ-017 After reset release, no word SHALL be produced before a WS edge is seen in SYNC.

Structure
REQ-018 Package i2s_pkg SHALL hold:
  - the FSM state enum (IDLE/SYNC/RUN);
  - the constants I2S_MAX_BITS = 32 and I2S_MAX_WORDS = 16.
REQ-019 Bit assembly (shreg, MSB/LSB placement, masking) SHALL be the sub-module i2s_rx_shifter; FSM, counters and handshake SHALL stay in the top.

Verification
REQ-020 The bench SHALL cover:
  - 16-bit MSB-first stereo (data_size=15, word_num=0), send 0xA5C3 left then 0x1234 right, ready=1 -> data_o 0x0000A5C3 ch 0x00, then 0x00001234 ch 0x10, one sck after each last bit.
  - LSB-first, data_size=7, word 0x81 sent LSB-first -> data_o 0x00000081.
  - 4-word TDM (word_num=3, data_size=31), ready held low after the first word -> words 2-4 dropped, overflow_o=1, data_o holds word 1; cfg_clr_i -> overflow_o=0.
  - WS toggled after 5 bits of a 16-bit word -> frame_err_o=1, no word output for that half, next full half-frame received correctly.
  - cfg_en_i dropped mid-word, re-enabled -> no partial word output, resync on the next WS edge.
  - rstn_i asserted mid-word -> all outputs 0 immediately, FSM IDLE.
